writeback_stage: RTL and testbench

- Final pipeline stage, directly upstream of the register file.
- Accepts completed results from execute over a valid/ready handshake and waits a fixed latency for load data.
- Drives the register file's single write port (write_en, Waddr, data_in) with registered outputs.
- Exports a same-cycle forwarding copy of the pending write. The register file reads combinationally and commits on the clock edge, so a same-cycle read returns the old value and consumers must bypass.

---
 rtl/writeback_stage.sv | 131 +++++++++++++
 tb/tb_writeback_stage.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_stage.sv
// Writeback stage: drives the register file write port and a forwarding copy.
// Optional define WB_RETIRE_COUNT_EN enables the saturating retire counter.
module writeback_stage #(
    parameter int W       = 8,
    parameter int D       = 4,
    parameter int MEM_LAT = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         ex_valid,
    output logic         ex_ready,
    input  logic         ex_wr,
    input  logic         ex_is_load,
    input  logic [D-1:0] ex_dest,
    input  logic [W-1:0] ex_result,
    input  logic [W-1:0] mem_rdata,
    output logic         rf_write_en,
    output logic [D-1:0] rf_waddr,
    output logic [W-1:0] rf_data,
    output logic         fwd_valid,
    output logic [D-1:0] fwd_addr,
    output logic [W-1:0] fwd_data,
    output logic         busy,
    output logic [15:0]  retire_count
);

    localparam int CW = 4;

    typedef enum logic {
        IDLE      = 1'b0,
        LOAD_WAIT = 1'b1
    } state_e;

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [D-1:0]   ldest_q, ldest_d;
    logic           we_q, we_d;
    logic [D-1:0]   waddr_q, waddr_d;
    logic [W-1:0]   data_q, data_d;
    logic           accept;

    assign ex_ready = (state_q == IDLE);
    assign busy     = (state_q == LOAD_WAIT);
    assign accept   = ex_valid & ex_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ldest_d = ldest_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        data_d  = data_q;
        unique case (state_q)
            IDLE: begin
                if (accept && ex_wr) begin
                    if (ex_is_load) begin
                        ldest_d = ex_dest;
                        cnt_d   = CW'(MEM_LAT - 1);
                        state_d = LOAD_WAIT;
                    end else begin
                        we_d    = 1'b1;
                        waddr_d = ex_dest;
                        data_d  = ex_result;
                    end
                end
            end
            LOAD_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    we_d    = 1'b1;
                    waddr_d = ldest_q;
                    data_d  = mem_rdata;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ldest_q <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ldest_q <= ldest_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            data_q  <= data_d;
        end
    end

    assign rf_write_en = we_q;
    assign rf_waddr    = waddr_q;
    assign rf_data     = data_q;

    // Register file commits on the edge, so same-cycle readers bypass via these
    assign fwd_valid = we_q;
    assign fwd_addr  = waddr_q;
    assign fwd_data  = data_q;

`ifdef WB_RETIRE_COUNT_EN
    logic [15:0] rc_q, rc_d;

    always_comb begin
        rc_d = rc_q;
        if (accept && rc_q != 16'hFFFF) begin
            rc_d = rc_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rc_q <= '0;
        end else begin
            rc_q <= rc_d;
        end
    end

    assign retire_count = rc_q;
`else
    assign retire_count = 16'h0000;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Randomized self-checking bench for writeback_stage against an edge-indexed model.
module tb_writeback_stage;

    localparam int W = 8;
    localparam int D = 4;
    localparam int MEM_LAT = 2;

    logic         clk = 1'b0;
    logic         reset;
    logic         ex_valid, ex_wr, ex_is_load;
    logic [D-1:0] ex_dest;
    logic [W-1:0] ex_result, mem_rdata;
    logic         ex_ready, rf_write_en, fwd_valid, busy;
    logic [D-1:0] rf_waddr, fwd_addr;
    logic [W-1:0] rf_data, fwd_data;
    logic [15:0]  retire_count;

    int total = 0;
    int bad = 0;

    // Model: the load sample happens at an absolute edge index
    int           n;
    int           load_edge;
    logic [D-1:0] load_dest;
    logic         m_we;
    logic [D-1:0] m_addr;
    logic [W-1:0] m_data;
    int unsigned  m_cnt;
    logic [15:0]  exp_rc;

    always #5 clk = ~clk;

    writeback_stage #(.W(W), .D(D), .MEM_LAT(MEM_LAT)) dut (
        .clk(clk), .reset(reset),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_wr(ex_wr), .ex_is_load(ex_is_load),
        .ex_dest(ex_dest), .ex_result(ex_result),
        .mem_rdata(mem_rdata),
        .rf_write_en(rf_write_en), .rf_waddr(rf_waddr), .rf_data(rf_data),
        .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
        .busy(busy), .retire_count(retire_count)
    );

    function automatic logic [15:0] rc_expect();
`ifdef WB_RETIRE_COUNT_EN
        return 16'(m_cnt);
`else
        return 16'h0000;
`endif
    endfunction

    task automatic model_reset();
        n = 0;
        load_edge = -1;
        load_dest = '0;
        m_we = 1'b0;
        m_addr = '0;
        m_data = '0;
        m_cnt = 0;
    endtask

    task automatic drive(input logic v, input logic wr, input logic ld,
                         input logic [D-1:0] dst, input logic [W-1:0] res);
        ex_valid = v;
        ex_wr = wr;
        ex_is_load = ld;
        ex_dest = dst;
        ex_result = res;
    endtask

    // Advance one edge, updating the model from the inputs present at the edge
    task automatic cycle();
        bit acc;
        acc = ex_valid && (load_edge < 0);
        n++;
        if (load_edge == n) begin
            m_we = 1'b1;
            m_addr = load_dest;
            m_data = mem_rdata;
            load_edge = -1;
        end else if (acc && ex_wr && !ex_is_load) begin
            m_we = 1'b1;
            m_addr = ex_dest;
            m_data = ex_result;
        end else begin
            m_we = 1'b0;
            if (acc && ex_wr && ex_is_load) begin
                load_edge = n + MEM_LAT;
                load_dest = ex_dest;
            end
        end
        if (acc && m_cnt < 65535) m_cnt++;
        exp_rc = rc_expect();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(0, 0, 0, '0, '0);
        mem_rdata = '0;
        model_reset();
        exp_rc = rc_expect();
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({rf_write_en, rf_waddr, rf_data} !== '0) begin
            bad++;
            $display("FAIL reset_rf got %b/%h/%h want 0/0/0", rf_write_en, rf_waddr, rf_data);
        end
        total++;
        if ({fwd_valid, fwd_addr, fwd_data, busy, ex_ready} !== {1'b0, 4'h0, 8'h00, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL reset_misc fwd=%b/%h/%h busy=%b ready=%b want 0/0/0 0 1",
                     fwd_valid, fwd_addr, fwd_data, busy, ex_ready);
        end
        total++;
        if (retire_count !== 16'h0000) begin
            bad++;
            $display("FAIL reset_rc got %h want 0000", retire_count);
        end
        reset = 1'b0;
    endtask

    task automatic test_alu_single();
        drive(1, 1, 0, 4'd3, 8'hA5);
        cycle();
        drive(0, 0, 0, '0, '0);
        total++;
        if ({rf_write_en, rf_waddr, rf_data, fwd_valid} !== {1'b1, 4'd3, 8'hA5, 1'b1}) begin
            bad++;
            $display("FAIL alu_write got %b/%h/%h fwd=%b want 1/3/a5 fwd=1",
                     rf_write_en, rf_waddr, rf_data, fwd_valid);
        end
        cycle();
        total++;
        if (rf_write_en !== 1'b0 || fwd_valid !== 1'b0) begin
            bad++;
            $display("FAIL alu_pulse we=%b fwd=%b want 0 0", rf_write_en, fwd_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] dat [3] = '{8'h11, 8'h22, 8'h33};
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 0, D'(i + 1), dat[i]);
            total++;
            if (ex_ready !== 1'b1) begin
                bad++;
                $display("FAIL b2b_ready%0d got %b want 1", i, ex_ready);
            end
            cycle();
            total++;
            if ({rf_write_en, rf_waddr, rf_data} !== {1'b1, D'(i + 1), dat[i]}) begin
                bad++;
                $display("FAIL b2b_write%0d got %b/%h/%h want 1/%h/%h",
                         i, rf_write_en, rf_waddr, rf_data, i + 1, dat[i]);
            end
        end
        drive(0, 0, 0, '0, '0);
        cycle();
    endtask

    task automatic test_load();
        int busy_cycles = 0;
        bool_wait: begin end
        drive(1, 1, 1, 4'd5, 8'hEE);
        cycle();
        // Follow-on ALU op held valid across the wait
        drive(1, 1, 0, 4'd9, 8'h77);
        for (int k = 0; k < MEM_LAT + 3; k++) begin
            mem_rdata = (n + 1 == load_edge) ? 8'h3C : 8'($urandom);
            total++;
            if (ex_ready !== (load_edge < 0) || busy !== (load_edge >= 0)) begin
                bad++;
                $display("FAIL load_hs%0d ready=%b busy=%b want %b %b",
                         k, ex_ready, busy, load_edge < 0, load_edge >= 0);
            end
            if (busy === 1'b1) busy_cycles++;
            cycle();
            total++;
            if ({rf_write_en, rf_waddr, rf_data} !== {m_we, m_addr, m_data}) begin
                bad++;
                $display("FAIL load_wr%0d got %b/%h/%h want %b/%h/%h",
                         k, rf_write_en, rf_waddr, rf_data, m_we, m_addr, m_data);
            end
            if (ex_valid && !ex_wr) drive(0, 0, 0, '0, '0);
            if (m_we && m_addr == 4'd9) drive(0, 0, 0, '0, '0);
        end
        total++;
        if (busy_cycles != MEM_LAT) begin
            bad++;
            $display("FAIL load_busy got %0d want %0d", busy_cycles, MEM_LAT);
        end
    endtask

    task automatic test_no_write();
        for (int i = 0; i < 2; i++) begin
            drive(1, 0, 1'(i), 4'd7, 8'h5A);
            cycle();
            total++;
            if (rf_write_en !== 1'b0 || busy !== 1'b0 || retire_count !== exp_rc) begin
                bad++;
                $display("FAIL nowr%0d we=%b busy=%b rc=%h want 0 0 %h",
                         i, rf_write_en, busy, retire_count, exp_rc);
            end
        end
        drive(0, 0, 0, '0, '0);
        cycle();
    endtask

    task automatic test_reset_in_load();
        drive(1, 1, 1, 4'd6, 8'h00);
        cycle();
        drive(0, 0, 0, '0, '0);
        #2 reset = 1'b1;
        model_reset();
        exp_rc = rc_expect();
        #1;
        total++;
        if (ex_ready !== 1'b1 || busy !== 1'b0 || rf_write_en !== 1'b0 || retire_count !== 16'h0) begin
            bad++;
            $display("FAIL rstld_async ready=%b busy=%b we=%b rc=%h want 1 0 0 0",
                     ex_ready, busy, rf_write_en, retire_count);
        end
        @(posedge clk);
        #2 reset = 1'b0;
        for (int k = 0; k < MEM_LAT + 2; k++) begin
            mem_rdata = 8'($urandom);
            total++;
            if (ex_ready !== 1'b1) begin
                bad++;
                $display("FAIL rstld_ready%0d got %b want 1", k, ex_ready);
            end
            cycle();
            total++;
            if (rf_write_en !== 1'b0) begin
                bad++;
                $display("FAIL rstld_nowr%0d got %b want 0", k, rf_write_en);
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            if (ex_ready === 1'b1 || !ex_valid)
                drive(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom_range(0, 3) == 0),
                      D'($urandom), W'($urandom));
            mem_rdata = W'($urandom);
            total++;
            if (ex_ready !== (load_edge < 0)) begin
                bad++;
                $display("FAIL rnd_ready%0d got %b want %b", k, ex_ready, load_edge < 0);
            end
            cycle();
            total++;
            if ({rf_write_en, rf_waddr, rf_data} !== {m_we, m_addr, m_data}) begin
                bad++;
                $display("FAIL rnd_rf%0d got %b/%h/%h want %b/%h/%h",
                         k, rf_write_en, rf_waddr, rf_data, m_we, m_addr, m_data);
            end
            total++;
            if ({fwd_valid, fwd_addr, fwd_data} !== {m_we, m_addr, m_data}
                || retire_count !== exp_rc) begin
                bad++;
                $display("FAIL rnd_fwd%0d got %b/%h/%h rc=%h want %b/%h/%h rc=%h",
                         k, fwd_valid, fwd_addr, fwd_data, retire_count,
                         m_we, m_addr, m_data, exp_rc);
            end
        end
        drive(0, 0, 0, '0, '0);
        while (load_edge >= 0) cycle();
        cycle();
    endtask

    task automatic test_saturation();
`ifdef WB_RETIRE_COUNT_EN
        drive(1, 0, 0, '0, '0);
        while (m_cnt < 65533) cycle();
        for (int i = 0; i < 4; i++) cycle();
        drive(0, 0, 0, '0, '0);
        cycle();
        total++;
        if (retire_count !== 16'hFFFF) begin
            bad++;
            $display("FAIL sat_rc got %h want ffff", retire_count);
        end
`else
        drive(1, 0, 0, '0, '0);
        repeat (2) cycle();
        drive(0, 0, 0, '0, '0);
        total++;
        if (retire_count !== 16'h0000) begin
            bad++;
            $display("FAIL sat_rc got %h want 0000", retire_count);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_alu_single();
        test_back_to_back();
        test_load();
        test_no_write();
        test_reset_in_load();
        test_random();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
